// File: rtl/mips_defs.sv
// Shared MIPS32 definitions for the fetch stage.
//   INST_NOP  : all-zero instruction (sll $0,$0,0)
//   RESET_PC  : default PC after reset
//   INST_W    : instruction / PC width
//   PC_INC    : sequential PC step
//   ce_state_t: ROM chip-enable FSM states
//   bswap32   : reverse byte order of a 32-bit word
package mips_defs;

  localparam int          INST_W   = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef enum logic {
    CE_IDLE = 1'b0,
    CE_RUN  = 1'b1
  } ce_state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter, ROM chip-enable FSM and next-PC selection.
//   clk, rst       : clock, synchronous active-high reset
//   stall          : hold the PC
//   flush          : advance/redirect even when stalled (flush beats stall)
//   branch_flag    : redirect to branch_target instead of pc+4
//   branch_target  : redirect address, low two bits dropped
//   pc             : current PC (always word aligned)
//   run            : FSM is in RUN, i.e. the ROM chip-enable
module pc_reg
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC_VAL = RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic        run
);

  ce_state_t   state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] target_aligned;

  // Misaligned targets are silently forced onto a word boundary.
  assign target_aligned = {branch_target[31:2], 2'b00};

  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CE_IDLE;
      pc_reg    <= RESET_PC_VAL;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      // The PC keeps its reset value for the cycle that enables the ROM.
      CE_IDLE: state_next = CE_RUN;
      CE_RUN: begin
        // Flush still moves the PC; a plain stall freezes it and drops
        // any branch request (the requester keeps it asserted).
        if (flush || !stall) begin
          pc_next = branch_flag ? target_aligned : pc_reg + PC_INC;
        end
      end
      default: state_next = CE_IDLE;
    endcase
  end

  assign pc  = pc_reg;
  assign run = (state_reg == CE_RUN);

endmodule

// File: rtl/inst_fetch.sv
// MIPS32 instruction-fetch stage: drives the instruction ROM and fills the
// IF/ID pipeline latch.
//   clk, rst       : clock, synchronous active-high reset
//   stall, flush   : hold / kill the IF/ID latch
//   branch_flag    : redirect the PC to branch_target
//   branch_target  : redirect address (bits [1:0] ignored)
//   rom_ce         : ROM chip-enable
//   rom_addr       : ROM word address = pc[ADDR_W+1:2] (driven even when ce=0)
//   rom_data       : combinational ROM data, little-endian byte order
//   if_pc/if_inst  : latched PC and instruction
//   if_valid       : latch holds a live instruction
module inst_fetch
  import mips_defs::*;
#(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = mips_defs::RESET_PC,
  parameter int          BSWAP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_flag,
  input  logic [31:0]       branch_target,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst,
  output logic              if_valid
);

  logic [31:0]       pc;
  logic              run;
  logic [INST_W-1:0] inst_w;

  logic [31:0] if_pc_reg;
  logic [31:0] if_inst_reg;
  logic        if_valid_reg;

  pc_reg #(
    .RESET_PC_VAL(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .pc           (pc),
    .run          (run)
  );

  assign rom_ce   = run;
  assign rom_addr = pc[ADDR_W+1:2];
  assign inst_w   = (BSWAP != 0) ? bswap32(rom_data) : rom_data;

  // The word fetched alongside a taken branch is its delay slot, so it is
  // latched like any other fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc_reg    <= 32'h0;
      if_inst_reg  <= INST_NOP;
      if_valid_reg <= 1'b0;
    end else if (run) begin
      if (flush) begin
        if_pc_reg    <= 32'h0;
        if_inst_reg  <= INST_NOP;
        if_valid_reg <= 1'b0;
      end else if (!stall) begin
        if_pc_reg    <= pc;
        if_inst_reg  <= inst_w;
        if_valid_reg <= 1'b1;
      end
    end
  end

  assign if_pc    = if_pc_reg;
  assign if_inst  = if_inst_reg;
  assign if_valid = if_valid_reg;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        rom_ce;
  logic [4:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  logic [31:0] rom [32];

  inst_fetch #(
    .ADDR_W  (5),
    .RESET_PC(32'h0),
    .BSWAP   (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .rom_ce       (rom_ce),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_valid     (if_valid)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic [31:0] ifpc;
    logic [31:0] inst;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_run;
  logic [31:0] m_pc;
  logic [31:0] m_ifpc;
  logic [31:0] m_inst;
  logic        m_valid;

  function automatic logic [31:0] swap_bytes(input logic [31:0] d);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(3-b) +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; expected post-edge state is queued for the monitor.
  task automatic step(input bit r, input bit st, input bit fl, input bit bf, input logic [31:0] bt);
    exp_t e;
    rst = r; stall = st; flush = fl; branch_flag = bf; branch_target = bt;
    if (r) begin
      m_run = 0; m_pc = 32'h0; m_ifpc = 0; m_inst = 0; m_valid = 0;
    end else if (!m_run) begin
      m_run = 1;
    end else if (fl) begin
      m_ifpc = 0; m_inst = 0; m_valid = 0;
      m_pc = bf ? (bt & ~32'd3) : m_pc + 32'd4;
    end else if (!st) begin
      m_ifpc  = m_pc;
      m_inst  = swap_bytes(rom[m_pc[6:2]]);
      m_valid = 1;
      m_pc = bf ? (bt & ~32'd3) : m_pc + 32'd4;
    end
    e.pc = m_pc; e.ce = m_run; e.ifpc = m_ifpc; e.inst = m_inst; e.valid = m_valid;
    @(posedge clk);
    exp_q.push_back(e);
    $display("txn rst=%0d stall=%0d flush=%0d br=%0d tgt=%h -> pc=%h ifpc=%h inst=%h v=%0d",
             r, st, fl, bf, bt, e.pc, e.ifpc, e.inst, e.valid);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rom_ce",   {31'b0, rom_ce},   {31'b0, e.ce});
      chk("rom_addr", {27'b0, rom_addr}, {27'b0, e.pc[6:2]});
      chk("if_pc",    if_pc,             e.ifpc);
      chk("if_inst",  if_inst,           e.inst);
      chk("if_valid", {31'b0, if_valid}, {31'b0, e.valid});
    end
  end

  initial begin
    // Program ROM: words 0..19 hold code, the rest read as zero (nop).
    for (int i = 0; i < 32; i++) rom[i] = (i < 20) ? $urandom : 32'h0;
    rom[0]  = 32'hFF00_0134;
    rom[3]  = 32'h0300_01A0;
    rom[18] = 32'h5544_013C;

    rst = 1; stall = 0; flush = 0; branch_flag = 0; branch_target = 0;
    m_run = 0; m_pc = 0; m_ifpc = 0; m_inst = 0; m_valid = 0;

    // 1: reset for three cycles, then enable and fetch word 0
    repeat (3) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("first_inst", if_inst, 32'h3401_00FF);
    step(0, 0, 0, 0, 0);
    // 3: stall at pc=0x08 for two cycles, branch request ignored
    step(0, 1, 0, 1, 32'h60);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);   // latches word 3
    chk("word3_swap", if_inst, 32'hA001_0003);
    // 4: branch at pc=0x10 to misaligned 0x43 -> delay slot latched, pc=0x40
    step(0, 0, 0, 1, 32'h43);
    // 5: flush with branch to 0x20, then flush+stall
    step(0, 0, 1, 1, 32'h20);
    step(0, 1, 1, 0, 0);
    // 2: branch to word 18 and fetch it
    step(0, 0, 0, 1, 32'h48);
    step(0, 0, 0, 0, 0);
    chk("word18_swap", if_inst, 32'h3C01_4455);
    // 6: reset mid-run, then branch to word 28 (past program, reads nop)
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h70);
    step(0, 0, 0, 0, 0);
    // PC wrap from 0xFFFFFFFC
    step(0, 0, 0, 1, 32'hFFFF_FFFE);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [31:0] tgt;
      r = $urandom_range(0, 99);
      tgt = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'h0000_00FF);
      step(r < 3, (r >= 11 && r < 26), (r >= 3 && r < 11),
           ($urandom_range(0, 5) == 0), tgt);
    end

    // Let the monitor drain, bounded
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
